// File: rtl/cam_pattern_gen_if.sv
// Camera-side signal bundle for cam_pattern_gen: run controls in, sensor-style
// VSYNC/HREF/DATA plus frame status out.
interface cam_pattern_gen_if;
  logic       enable;
  logic [1:0] pattern_sel;
  logic       cam_vsync;
  logic       cam_href;
  logic [7:0] cam_d;
  logic       frame_done;
  logic [7:0] frame_count;
  logic       busy;

  modport master (
    input  enable, pattern_sel,
    output cam_vsync, cam_href, cam_d, frame_done, frame_count, busy
  );

  modport slave (
    output enable, pattern_sel,
    input  cam_vsync, cam_href, cam_d, frame_done, frame_count, busy
  );
endinterface

// File: rtl/cam_pattern_gen.sv
// Synthetic camera source: sensor-style frame timing with run-time selectable
// test patterns. Define CAMGEN_LFSR_EN to turn pattern 3 into an LFSR stream.
module cam_pattern_gen #(
  parameter int unsigned H_ACTIVE = 160,
  parameter int unsigned H_BLANK  = 40,
  parameter int unsigned V_SYNC   = 3,
  parameter int unsigned V_BACK   = 10,
  parameter int unsigned V_ACTIVE = 120,
  parameter int unsigned V_FRONT  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  cam_pattern_gen_if.master     bus
);

  localparam int unsigned H_TOTAL    = H_ACTIVE + H_BLANK;
  localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT      = 12'(H_ACTIVE);
  localparam logic [11:0] SYNC_LAST  = 12'(V_SYNC - 1);
  localparam logic [11:0] BACK_LAST  = 12'(V_BACK - 1);
  localparam logic [11:0] ACT_LAST   = 12'(V_ACTIVE - 1);
  localparam logic [11:0] FRONT_LAST = 12'(V_FRONT - 1);
  localparam bit          HAS_BACK   = (V_BACK != 0);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    BACK,
    ACTIVE,
    FRONT
  } state_t;

  state_t      state_q, state_d;
  logic [11:0] hcnt_q, hcnt_d;
  logic [11:0] vcnt_q, vcnt_d;
  logic [1:0]  psel_q, psel_d;
  logic        vsync_q, vsync_d;
  logic        href_q, href_d;
  logic [7:0]  camd_q, camd_d;
  logic        done_q, done_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic        busy_q, busy_d;

  logic        line_end;
  logic        last_line;
  logic        advance;
  logic        start;

`ifdef CAMGEN_LFSR_EN
  logic [7:0]  lfsr_q, lfsr_d;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      psel_q  <= '0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      camd_q  <= '0;
      done_q  <= 1'b0;
      fcnt_q  <= '0;
      busy_q  <= 1'b0;
`ifdef CAMGEN_LFSR_EN
      lfsr_q  <= 8'h01;
`endif
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      psel_q  <= psel_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      camd_q  <= camd_d;
      done_q  <= done_d;
      fcnt_q  <= fcnt_d;
      busy_q  <= busy_d;
`ifdef CAMGEN_LFSR_EN
      lfsr_q  <= lfsr_d;
`endif
    end
  end

  // Next-state and counters; outputs below are derived from the *next* state so
  // that every registered output lines up with the state it describes.
  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    start     = 1'b0;
    line_end  = (hcnt_q == H_LAST);

    case (state_q)
      SYNC:    last_line = (vcnt_q == SYNC_LAST);
      BACK:    last_line = (vcnt_q == BACK_LAST);
      ACTIVE:  last_line = (vcnt_q == ACT_LAST);
      FRONT:   last_line = (vcnt_q == FRONT_LAST);
      default: last_line = 1'b0;
    endcase
    advance = line_end && last_line;

    if (state_q == IDLE) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else begin
      hcnt_d = line_end ? '0 : hcnt_q + 12'd1;
      if (advance) begin
        vcnt_d = '0;
      end else if (line_end) begin
        vcnt_d = vcnt_q + 12'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.enable) begin
          state_d = SYNC;
          start   = 1'b1;
        end
      end
      SYNC: begin
        if (advance) state_d = HAS_BACK ? BACK : ACTIVE;
      end
      BACK: begin
        if (advance) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (advance) state_d = FRONT;
      end
      FRONT: begin
        if (advance) begin
          if (bus.enable) begin
            state_d = SYNC;
            start   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    psel_d = start ? bus.pattern_sel : psel_q;
  end

  always_comb begin
    vsync_d = (state_d == SYNC);
    href_d  = (state_d == ACTIVE) && (hcnt_d < H_ACT);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == FRONT) && (hcnt_d == H_LAST) && (vcnt_d == FRONT_LAST);
    fcnt_d  = done_d ? fcnt_q + 8'd1 : fcnt_q;

    camd_d  = '0;
    if (href_d) begin
      case (psel_q)
        2'd0:    camd_d = hcnt_d[7:0];
        2'd1:    camd_d = vcnt_d[7:0];
        2'd2:    camd_d = (hcnt_d[3] ^ vcnt_d[3]) ? 8'hFF : 8'h00;
`ifdef CAMGEN_LFSR_EN
        default: camd_d = lfsr_q;
`else
        default: camd_d = fcnt_q;
`endif
      endcase
    end
  end

`ifdef CAMGEN_LFSR_EN
  // x^8+x^6+x^5+x^4+1, shifted left; only steps on bytes actually emitted.
  always_comb begin
    lfsr_d = lfsr_q;
    if (start) begin
      lfsr_d = 8'h01;
    end else if (href_d) begin
      lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end
`endif

  assign bus.cam_vsync   = vsync_q;
  assign bus.cam_href    = href_q;
  assign bus.cam_d       = camd_q;
  assign bus.frame_done  = done_q;
  assign bus.frame_count = fcnt_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_cam_pattern_gen.sv
// Bench for cam_pattern_gen: frame-timer reference model feeding a scoreboard
// queue, plus directed checks on geometry, latching, disable and reset.
module tb_cam_pattern_gen;

  localparam int unsigned H_ACTIVE = 16;
  localparam int unsigned H_BLANK  = 4;
  localparam int unsigned V_SYNC   = 1;
  localparam int unsigned V_BACK   = 1;
  localparam int unsigned V_ACTIVE = 2;
  localparam int unsigned V_FRONT  = 1;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_BLANK;
  localparam int unsigned FRAME    = (V_SYNC + V_BACK + V_ACTIVE + V_FRONT) * H_TOTAL;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  cam_pattern_gen_if bus();

  cam_pattern_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_BLANK  (H_BLANK),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK),
    .V_ACTIVE (V_ACTIVE),
    .V_FRONT  (V_FRONT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       vs;
    logic       hr;
    logic [7:0] d;
    logic       done;
    logic [7:0] fc;
    logic       busy;
  } obs_t;

  obs_t        exp_q[$];
  obs_t        obs;
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;

  // Reference model: a single frame timer, geometry decoded from it.
  bit          m_run  = 1'b0;
  int unsigned m_t    = 0;
  logic [7:0]  m_fc   = '0;
  logic [1:0]  m_psel = '0;
  logic [7:0]  m_lfsr = 8'h01;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    assert (got === want) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic model_step();
    obs_t        e;
    int unsigned line, x, y;
    if (reset) begin
      m_run = 1'b0; m_t = 0; m_fc = '0; m_psel = '0;
    end else if (!m_run) begin
      if (bus.enable) begin
        m_run = 1'b1; m_t = 0; m_psel = bus.pattern_sel; m_lfsr = 8'h01;
      end
    end else if (m_t == FRAME - 1) begin
      if (bus.enable) begin
        m_t = 0; m_psel = bus.pattern_sel; m_lfsr = 8'h01;
      end else begin
        m_run = 1'b0;
      end
    end else begin
      m_t++;
    end

    e = '0;
    if (m_run) begin
      line   = m_t / H_TOTAL;
      x      = m_t % H_TOTAL;
      e.busy = 1'b1;
      e.vs   = (line < V_SYNC);
      if (m_t == FRAME - 1) begin
        m_fc++;
        e.done = 1'b1;
      end
      if (line >= V_SYNC + V_BACK && line < V_SYNC + V_BACK + V_ACTIVE && x < H_ACTIVE) begin
        y    = line - V_SYNC - V_BACK;
        e.hr = 1'b1;
        case (m_psel)
          2'd0: e.d = x[7:0];
          2'd1: e.d = y[7:0];
          2'd2: e.d = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
          default: begin
`ifdef CAMGEN_LFSR_EN
            e.d    = m_lfsr;
            m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`else
            e.d    = m_fc;
`endif
          end
        endcase
      end
    end
    e.fc = m_fc;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    obs_t e;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    obs.vs   = bus.cam_vsync;
    obs.hr   = bus.cam_href;
    obs.d    = bus.cam_d;
    obs.done = bus.frame_done;
    obs.fc   = bus.frame_count;
    obs.busy = bus.busy;
    e = exp_q.pop_front();
    check($sformatf("sb@%0d", cyc), 32'(obs), 32'(e));
  endtask

  int unsigned vs_cnt, hr_cnt, done_at, nd;
  int unsigned done_times [4];
  logic [7:0]  cap [3][16];
  int unsigned ncap [3];
  logic [7:0]  lfsr_ref [8];

  initial begin
    lfsr_ref = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
    bus.enable      = 1'b0;
    bus.pattern_sel = 2'd0;

    // Reset and idle
    tick(); tick();
    check("rst_state", 32'(obs), 32'd0);
    reset = 1'b0;
    repeat (5) tick();
    check("idle_busy", 32'(obs.busy), 32'd0);
    check("idle_vsync", 32'(obs.vs), 32'd0);

    // Single frame, pattern 0, enable dropped at clock 30
    bus.enable = 1'b1;
    tick();
    check("start_vsync", 32'(obs.vs), 32'd1);
    check("start_busy", 32'(obs.busy), 32'd1);
    vs_cnt = 1; hr_cnt = 0; done_at = 0;
    for (int unsigned c = 2; c <= FRAME; c++) begin
      if (c == 30) bus.enable = 1'b0;
      tick();
      if (obs.vs)   vs_cnt++;
      if (obs.hr)   hr_cnt++;
      if (obs.done) done_at = c;
    end
    check("vsync_clks", vs_cnt, V_SYNC * H_TOTAL);
    check("href_clks", hr_cnt, V_ACTIVE * H_ACTIVE);
    check("done_clock", done_at, FRAME);
    check("fc_after1", 32'(obs.fc), 32'd1);
    vs_cnt = 0;
    repeat (30) begin
      tick();
      if (obs.vs) vs_cnt++;
    end
    check("no_restart_vsync", vs_cnt, 0);
    check("idle_after_disable", 32'(obs.busy), 32'd0);

    // Continuous run with pattern switches, then reset during ACTIVE
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.pattern_sel = 2'd0;
    bus.enable = 1'b1;
    nd = 0;
    ncap = '{0, 0, 0};
    for (int unsigned c = 1; c <= 3 * FRAME + 45; c++) begin
      if (c == 25)         bus.pattern_sel = 2'd2;
      if (c == FRAME + 25) bus.pattern_sel = 2'd3;
      tick();
      if (obs.done && nd < 4) begin
        done_times[nd] = c;
        nd++;
      end
      if (obs.hr && (c - 1) / FRAME < 3 && ncap[(c - 1) / FRAME] < 16) begin
        cap[(c - 1) / FRAME][ncap[(c - 1) / FRAME]] = obs.d;
        ncap[(c - 1) / FRAME]++;
      end
      if (c == 3 * FRAME) check("fc_after3", 32'(obs.fc), 32'd3);
    end
    check("done_count", nd, 3);
    check("done_first", done_times[0], FRAME);
    check("done_gap1", done_times[1] - done_times[0], FRAME);
    check("done_gap2", done_times[2] - done_times[1], FRAME);
    for (int unsigned i = 0; i < 16; i++) begin
      check($sformatf("ramp[%0d]", i), 32'(cap[0][i]), i);
      check($sformatf("checker[%0d]", i), 32'(cap[1][i]), (i < 8) ? 32'h00 : 32'hFF);
    end
`ifdef CAMGEN_LFSR_EN
    for (int unsigned i = 0; i < 8; i++)
      check($sformatf("lfsr[%0d]", i), 32'(cap[2][i]), 32'(lfsr_ref[i]));
`else
    for (int unsigned i = 0; i < 8; i++)
      check($sformatf("tag[%0d]", i), 32'(cap[2][i]), 32'd2);
`endif
    check("pre_reset_href", 32'(obs.hr), 32'd1);

    reset = 1'b1;
    tick();
    check("mid_rst_href", 32'(obs.hr), 32'd0);
    check("mid_rst_d", 32'(obs.d), 32'd0);
    check("mid_rst_fc", 32'(obs.fc), 32'd0);
    check("mid_rst_busy", 32'(obs.busy), 32'd0);
    reset = 1'b0;
    tick();
    check("restart_vsync", 32'(obs.vs), 32'd1);
    check("restart_busy", 32'(obs.busy), 32'd1);
    bus.enable = 1'b0;
    repeat (FRAME + 5) tick();
    check("final_busy", 32'(obs.busy), 32'd0);
    check("final_fc", 32'(obs.fc), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
